// File: rtl/tpsram_fifo_pkg.sv
// Shared constants and output-stage state type for the two-port SRAM FWFT FIFO controller.
package tpsram_fifo_pkg;

    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 6;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int AFULL_TH = 60;

    typedef enum logic {
        EMPTY = 1'b0,
        HEAD  = 1'b1
    } out_state_t;

endpackage

// File: rtl/tpsram_fifo_ptr.sv
// Wrap-around RAM address pointer with increment enable; used for both write and read sides.
module tpsram_fifo_ptr #(
    parameter int ADDR_W = tpsram_fifo_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;

    // Natural binary overflow gives the mod-DEPTH wrap since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/tpsram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a 1-cycle-read two-port SRAM.
// Optional sticky OVERFLOW/UNDERFLOW flags are built only when FIFO_ERR_FLAGS_EN is defined.
module tpsram_fifo_ctrl
    import tpsram_fifo_pkg::*;
#(
    parameter int DATA_W   = tpsram_fifo_pkg::DATA_W,
    parameter int ADDR_W   = tpsram_fifo_pkg::ADDR_W,
    parameter int AFULL_TH = tpsram_fifo_pkg::AFULL_TH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              FULL,
    output logic              ALMOST_FULL,
    input  logic              POP,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [ADDR_W:0]   LEVEL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic [ADDR_W-1:0] RAM_W_ADDR,
    output logic [DATA_W-1:0] RAM_W_DATA,
    output logic              RAM_W_EN,
    output logic [ADDR_W-1:0] RAM_R_ADDR,
    output logic              RAM_R_EN,
    input  logic [DATA_W-1:0] RAM_R_DATA
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int DEPTH_L = 1 << ADDR_W;

    out_state_t       r_state;
    logic [CNT_W-1:0] r_ram_cnt;
    logic             r_full;
    logic             r_afull;
    logic [CNT_W-1:0] r_level;

    logic             w_push_acc;
    logic             w_pop_acc;
    logic             w_rd_issue;
    logic             w_rd_valid;
    logic             w_rd_valid_next;
    logic [CNT_W-1:0] w_ram_cnt_next;
    logic [CNT_W-1:0] w_level_next;

    assign w_rd_valid = (r_state == HEAD);
    assign w_push_acc = PUSH && !r_full;
    assign w_pop_acc  = POP && w_rd_valid;
    assign w_rd_issue = (r_ram_cnt != '0) && (!w_rd_valid || w_pop_acc);

    assign w_ram_cnt_next  = r_ram_cnt + {{ADDR_W{1'b0}}, w_push_acc} - {{ADDR_W{1'b0}}, w_rd_issue};
    assign w_rd_valid_next = w_rd_issue || (w_rd_valid && !w_pop_acc);
    assign w_level_next    = w_ram_cnt_next + {{ADDR_W{1'b0}}, w_rd_valid_next};

    tpsram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .i_clk (CLK),
        .i_rst (RST),
        .i_inc (w_push_acc),
        .o_ptr (RAM_W_ADDR)
    );

    tpsram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .i_clk (CLK),
        .i_rst (RST),
        .i_inc (w_rd_issue),
        .o_ptr (RAM_R_ADDR)
    );

    // Head register is the RAM read port itself; the FSM only tracks whether it holds a live word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_rd_issue) r_state <= HEAD;
                HEAD:    if (w_pop_acc && !w_rd_issue) r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase
        end
    end

    // FULL counts RAM entries only, so a read issued in the same cycle never rescues a push.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ram_cnt <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_level   <= '0;
        end else begin
            r_ram_cnt <= w_ram_cnt_next;
            r_full    <= (w_ram_cnt_next == CNT_W'(DEPTH_L));
            r_afull   <= (w_level_next >= CNT_W'(AFULL_TH));
            r_level   <= w_level_next;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (PUSH && r_full)      r_overflow  <= 1'b1;
            if (POP && !w_rd_valid)  r_underflow <= 1'b1;
        end
    end

    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

    assign FULL        = r_full;
    assign ALMOST_FULL = r_afull;
    assign LEVEL       = r_level;
    assign RD_VALID    = w_rd_valid;
    assign RD_DATA     = RAM_R_DATA;
    assign RAM_W_DATA  = WR_DATA;
    assign RAM_W_EN    = w_push_acc;
    assign RAM_R_EN    = w_rd_issue;

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Self-checking bench for tpsram_fifo_ctrl with a behavioural 64x20 two-port RAM and a word scoreboard.
module tb_tpsram_fifo_ctrl;

    localparam int DW = 20;
    localparam int AW = 6;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          PUSH = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          POP = 1'b0;
    logic          FULL, ALMOST_FULL, RD_VALID, OVERFLOW, UNDERFLOW;
    logic [DW-1:0] RD_DATA;
    logic [AW:0]   LEVEL;
    logic [AW-1:0] RAM_W_ADDR, RAM_R_ADDR;
    logic [DW-1:0] RAM_W_DATA, RAM_R_DATA;
    logic          RAM_W_EN, RAM_R_EN;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int            mRamCnt = 0;
    bit            mValid = 1'b0;
    bit            mFull = 1'b0;
    bit            mOvf = 1'b0;
    bit            mUnf = 1'b0;
    logic [DW-1:0] sbQ[$];

    logic [DW-1:0] ramMem [64];

    always #5 CLK = ~CLK;

    // Behavioural RAM: registered read, output holds while read enable is low.
    always @(posedge CLK) begin
        if (RAM_W_EN) ramMem[RAM_W_ADDR] <= RAM_W_DATA;
        if (RAM_R_EN) RAM_R_DATA <= ramMem[RAM_R_ADDR];
    end

    tpsram_fifo_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .PUSH        (PUSH),
        .WR_DATA     (WR_DATA),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .POP         (POP),
        .RD_VALID    (RD_VALID),
        .RD_DATA     (RD_DATA),
        .LEVEL       (LEVEL),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW),
        .RAM_W_ADDR  (RAM_W_ADDR),
        .RAM_W_DATA  (RAM_W_DATA),
        .RAM_W_EN    (RAM_W_EN),
        .RAM_R_ADDR  (RAM_R_ADDR),
        .RAM_R_EN    (RAM_R_EN),
        .RAM_R_DATA  (RAM_R_DATA)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkState();
        int lvl;
        lvl = mRamCnt + int'(mValid);
        checkOutput("level", 32'(LEVEL), 32'(lvl));
        checkOutput("rd_valid", 32'(RD_VALID), 32'(mValid));
        checkOutput("full", 32'(FULL), 32'(mFull));
        checkOutput("almost_full", 32'(ALMOST_FULL), 32'(lvl >= 60));
        checkOutput("overflow", 32'(OVERFLOW), 32'(FLAGS_ON && mOvf));
        checkOutput("underflow", 32'(UNDERFLOW), 32'(FLAGS_ON && mUnf));
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RST = 1'b1;
        PUSH = 1'b0;
        POP = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mRamCnt = 0;
        mValid = 1'b0;
        mFull = 1'b0;
        mOvf = 1'b0;
        mUnf = 1'b0;
        sbQ.delete();
        checkOutput("rst_level", 32'(LEVEL), 32'd0);
        checkOutput("rst_rd_valid", 32'(RD_VALID), 32'd0);
        checkOutput("rst_full", 32'(FULL), 32'd0);
        checkOutput("rst_afull", 32'(ALMOST_FULL), 32'd0);
        checkOutput("rst_ovf", 32'(OVERFLOW), 32'd0);
        checkOutput("rst_unf", 32'(UNDERFLOW), 32'd0);
    endtask

    // One clock cycle: drive, check combinational controls and popped word, then advance the model.
    task automatic applyStimulus(input bit push, input logic [DW-1:0] data, input bit pop);
        bit pushAcc, popAcc, issue;
        logic [DW-1:0] expWord;
        @(negedge CLK);
        PUSH = push;
        WR_DATA = data;
        POP = pop;
        pushAcc = push && !mFull;
        popAcc = pop && mValid;
        issue = (mRamCnt != 0) && (!mValid || popAcc);
        #1;
        checkOutput("ram_w_en", 32'(RAM_W_EN), 32'(pushAcc));
        checkOutput("ram_r_en", 32'(RAM_R_EN), 32'(issue));
        if (pushAcc) checkOutput("ram_w_data", 32'(RAM_W_DATA), 32'(data));
        if (popAcc && sbQ.size() > 0) begin
            expWord = sbQ.pop_front();
            checkOutput("rd_data", 32'(RD_DATA), 32'(expWord));
        end
        @(posedge CLK);
        if (push && mFull) mOvf = 1'b1;
        if (pop && !mValid) mUnf = 1'b1;
        mRamCnt = mRamCnt + int'(pushAcc) - int'(issue);
        mValid = issue || (mValid && !popAcc);
        mFull = (mRamCnt == 64);
        if (pushAcc) sbQ.push_back(data);
        #1;
        checkState();
    endtask

    initial begin
        logic [DW-1:0] word;

        $display("[TB] start, error flags %0s", FLAGS_ON ? "enabled" : "disabled");

        // Basic three-word stream with consumer always ready
        applyReset();
        applyStimulus(1'b1, 20'h00001, 1'b1);
        checkOutput("latency_edge1", 32'(RD_VALID), 32'd0);
        applyStimulus(1'b1, 20'h00002, 1'b1);
        checkOutput("latency_edge2", 32'(RD_VALID), 32'd1);
        checkOutput("first_word", 32'(RD_DATA), 32'h00001);
        applyStimulus(1'b1, 20'h00003, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drained_level", 32'(LEVEL), 32'd0);

        // Fill to full with one refused push
        applyReset();
        for (int i = 0; i < 66; i++) applyStimulus(1'b1, DW'(20'h10000 + i), 1'b0);
        checkOutput("fill_full", 32'(FULL), 32'd1);
        checkOutput("fill_level", 32'(LEVEL), 32'd65);
        checkOutput("fill_afull", 32'(ALMOST_FULL), 32'd1);
        checkOutput("fill_ovf", 32'(OVERFLOW), 32'(FLAGS_ON));

        // Simultaneous push/pop while full, across pointer wrap
        word = 20'h20000;
        applyStimulus(1'b1, word, 1'b1);
        checkOutput("full_refuse_full", 32'(FULL), 32'd0);
        checkOutput("full_refuse_level", 32'(LEVEL), 32'd64);
        for (int i = 1; i < 200; i++) begin
            word = word + 1'b1;
            applyStimulus(1'b1, word, 1'b1);
        end
        checkOutput("stream_level", 32'(LEVEL), 32'd64);

        // Pop on an empty FIFO
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("empty_rd_valid", 32'(RD_VALID), 32'd0);
        checkOutput("empty_unf", 32'(UNDERFLOW), 32'(FLAGS_ON));

        // Reset mid-transfer discards stored words
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, DW'(20'h30000 + i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        applyReset();
        applyStimulus(1'b1, 20'hABCDE, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_head", 32'(RD_DATA), 32'hABCDE);
        applyStimulus(1'b0, '0, 1'b1);

        // Random traffic
        applyReset();
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(bit'($urandom_range(1, 0)), DW'($urandom), bit'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
